// File: rtl/mul_div_if.sv
// Operand/result bundle between the execute stage and the multiply/divide unit.
interface mul_div_if #(
  parameter int WIDTH = 32
) ();
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;

  modport master (
    output start, op, A, B,
    input  hi, lo, busy, done
  );

  modport slave (
    input  start, op, A, B,
    output hi, lo, busy, done
  );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative radix-2 multiply/divide unit holding the architectural HI/LO pair.
// Multiply and divide share one 2*WIDTH accumulator: the upper half is the
// partial product / running remainder, the lower half is the multiplier /
// dividend being consumed (and the quotient being built for divide).
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting; MTHI/MTLO write directly, MULT/DIV latch operands
//   CALC  | one shift-add / restoring shift-subtract step per edge
//   FIX   | sign correction, HI/LO write, done pulse
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input logic     clk,
  input logic     rstn,
  mul_div_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;
  logic               sign_a_q, sign_a_d;
  logic [WIDTH-1:0]   opd_q, opd_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic               signed_op;
  logic               sa, sb;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  // Operand magnitudes for the signed ops; unsigned ops pass through raw.
  always_comb begin
    signed_op = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    sa        = signed_op & bus.A[WIDTH-1];
    sb        = signed_op & bus.B[WIDTH-1];
    mag_a     = sa ? (~bus.A + 1'b1) : bus.A;
    mag_b     = sb ? (~bus.B + 1'b1) : bus.B;
  end

  // One iteration of each algorithm, plus the final sign fix-up.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opd_q} : '0);
    mul_next  = {mul_sum, acc_q[WIDTH-1:1]};

    div_shift = acc_q[2*WIDTH-1:WIDTH-1];
    div_diff  = div_shift - {1'b0, opd_q};
    if (!div_diff[WIDTH]) begin
      div_next = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      div_next = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end

    prod_fix  = neg_q ? (~acc_q + 1'b1) : acc_q;
    quo_fix   = neg_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
    // With a zero divisor every step subtracts nothing, so the remainder ends
    // up equal to |A|; restoring the sign of A then yields the raw A.
    rem_fix   = sign_a_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
  end

  // Next-state and datapath control.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    sign_a_d = sign_a_q;
    opd_d    = opd_q;
    acc_d    = acc_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          unique case (bus.op)
            OP_MTHI: hi_d = bus.A;
            OP_MTLO: lo_d = bus.A;
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              is_div_d = bus.op[1];
              neg_d    = sa ^ sb;
              sign_a_d = sa;
              if (bus.op[1]) begin
                opd_d = mag_b;
                acc_d = {{WIDTH{1'b0}}, mag_a};
              end else begin
                opd_d = mag_a;
                acc_d = {{WIDTH{1'b0}}, mag_b};
              end
              cnt_d   = '0;
              state_d = CALC;
            end
            default: ;
          endcase
        end
      end
      CALC: begin
        acc_d = is_div_q ? div_next : mul_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = (opd_q == '0) ? '1 : quo_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      sign_a_q <= 1'b0;
      opd_q    <= '0;
      acc_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      sign_a_q <= sign_a_d;
      opd_q    <= opd_d;
      acc_q    <= acc_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign bus.busy = (state_q != IDLE);
  assign bus.done = done_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: cycle-level reference model plus directed vectors.
module tb_mul_div_unit;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  int checks = 0;
  int errors = 0;

  mul_div_if #(.WIDTH(32)) bus ();

  mul_div_unit #(.WIDTH(32)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Reference arithmetic, straight from the instruction definitions.
  function automatic void ref_calc(input bit [2:0] op, input bit [31:0] a, input bit [31:0] b,
                                   output bit [31:0] h, output bit [31:0] l);
    longint    sp;
    bit [63:0] up;
    int        q, r;
    h = 0;
    l = 0;
    case (op)
      3'd0: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        h  = sp[63:32];
        l  = sp[31:0];
      end
      3'd1: begin
        up = {32'b0, a} * {32'b0, b};
        h  = up[63:32];
        l  = up[31:0];
      end
      3'd2: begin
        if (b == 0) begin
          l = 32'hFFFFFFFF;
          h = a;
        end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
          l = 32'h80000000;
          h = 0;
        end else begin
          q = $signed(a) / $signed(b);
          r = $signed(a) % $signed(b);
          l = q;
          h = r;
        end
      end
      3'd3: begin
        if (b == 0) begin
          l = 32'hFFFFFFFF;
          h = a;
        end else begin
          l = a / b;
          h = a % b;
        end
      end
      default: ;
    endcase
  endfunction

  // Cycle model: an accepted MULT/DIV keeps the unit busy for 33 edges, and
  // the result lands together with a one-cycle done on the last of them.
  bit [31:0] exp_hi = 0, exp_lo = 0, pend_hi = 0, pend_lo = 0, ph, pl;
  bit        exp_done = 0;
  int        left = 0;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      exp_hi   <= 0;
      exp_lo   <= 0;
      exp_done <= 0;
      left     <= 0;
    end else begin
      exp_done <= 0;
      if (left > 0) begin
        left <= left - 1;
        if (left == 1) begin
          exp_hi   <= pend_hi;
          exp_lo   <= pend_lo;
          exp_done <= 1;
        end
      end else if (bus.start) begin
        case (bus.op)
          3'd4: exp_hi <= bus.A;
          3'd5: exp_lo <= bus.A;
          3'd0, 3'd1, 3'd2, 3'd3: begin
            ref_calc(bus.op, bus.A, bus.B, ph, pl);
            pend_hi <= ph;
            pend_lo <= pl;
            left    <= 33;
          end
          default: ;
        endcase
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (rstn) begin
      chk("cyc_hi", bus.hi, exp_hi);
      chk("cyc_lo", bus.lo, exp_lo);
      chk("cyc_busy", 32'(bus.busy), 32'(left > 0));
      chk("cyc_done", 32'(bus.done), 32'(exp_done));
    end
  end

  task automatic start_op(input bit [2:0] op, input bit [31:0] a, input bit [31:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.A     = a;
    bus.B     = b;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Returns at the first negedge with busy low; n counts busy cycles seen.
  task automatic wait_done(output int n);
    n = 0;
    while (bus.busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("wait_busy_bound", 32'(bus.busy), 32'd0);
    chk("done_with_first_idle", 32'(bus.done), 32'd1);
  endtask

  task automatic run_op(input string nm, input bit [2:0] op, input bit [31:0] a,
                        input bit [31:0] b, input bit [31:0] eh, input bit [31:0] el);
    int n;
    start_op(op, a, b);
    wait_done(n);
    chk({nm, "_hi"}, bus.hi, eh);
    chk({nm, "_lo"}, bus.lo, el);
  endtask

  initial begin
    int n;
    bus.start = 1'b0;
    bus.op    = 3'd0;
    bus.A     = '0;
    bus.B     = '0;

    // Reset state
    rstn = 1'b0;
    #12;
    chk("rst_hi", bus.hi, 0);
    chk("rst_lo", bus.lo, 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_hi", bus.hi, 0);
    chk("post_rst_lo", bus.lo, 0);
    chk("post_rst_busy", 32'(bus.busy), 0);

    // MULT with latency and done timing
    start_op(3'd0, 32'hFFFFFFFD, 32'd7);
    wait_done(n);
    chk("mult_busy_cycles", 32'(n), 32'd33);
    chk("mult_hi", bus.hi, 32'hFFFFFFFF);
    chk("mult_lo", bus.lo, 32'hFFFFFFEB);
    @(negedge clk);
    chk("mult_done_one_cycle", 32'(bus.done), 0);

    run_op("multu_max", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_op("mult_negneg", 3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001);
    run_op("div_neg", 3'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("div_pos_neg", 3'd2, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
    run_op("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    run_op("divu_zero", 3'd3, 32'd7, 32'd0, 32'd7, 32'hFFFFFFFF);
    run_op("div_zero_neg", 3'd2, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF);

    // Idle MTHI writes after one edge, no busy/done
    start_op(3'd4, 32'h12345678, 32'd0);
    chk("mthi_hi", bus.hi, 32'h12345678);
    chk("mthi_busy", 32'(bus.busy), 0);
    chk("mthi_done", 32'(bus.done), 0);

    // MTLO while busy is ignored
    start_op(3'd3, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    start_op(3'd5, 32'hDEADBEEF, 32'd0);
    wait_done(n);
    chk("divu_mtlo_hi", bus.hi, 32'd2);
    chk("divu_mtlo_lo", bus.lo, 32'd14);

    // Reset mid-operation
    start_op(3'd1, 32'd5, 32'd6);
    repeat (8) @(negedge clk);
    #2;
    rstn = 1'b0;
    #1;
    chk("midrst_hi", bus.hi, 0);
    chk("midrst_lo", bus.lo, 0);
    chk("midrst_busy", 32'(bus.busy), 0);
    chk("midrst_done", 32'(bus.done), 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk("after_rst_no_done", 32'(bus.done), 0);
    end
    run_op("multu_5x6", 3'd1, 32'd5, 32'd6, 32'd0, 32'd30);

    // Unused opcode is ignored
    start_op(3'd7, 32'hAAAA5555, 32'd1);
    chk("op7_busy", 32'(bus.busy), 0);
    chk("op7_hi", bus.hi, 32'd0);
    chk("op7_lo", bus.lo, 32'd30);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
